// File: rtl/hub_norm_arbiter.sv
// Round-robin normalizer shared by two FP HUB adder requesters: drives one external LZA,
// left-normalizes the sum with a one-step under-count fix. Define HUB_NORM_STATS_EN for fix/uflow counters.
module hub_norm_arbiter #(
  parameter int M  = 24,
  parameter int E  = 8,
  parameter int SW = $clog2(M+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*(M+1)-1:0] req_a,
  input  logic [2*(M+1)-1:0] req_b,
  input  logic [2*(M+1)-1:0] req_sum,
  input  logic [2*E-1:0]    req_exp,
  output logic [M:0]        lza_a,
  output logic [M:0]        lza_b,
  input  logic [SW-1:0]     lza_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_id,
  output logic [M:0]        out_mant,
  output logic [E-1:0]      out_exp,
  output logic              out_zero,
  output logic              out_uflow
`ifdef HUB_NORM_STATS_EN
  ,
  output logic [15:0]       fix_cnt,
  output logic [15:0]       uflow_cnt
`endif
);

  typedef enum logic [2:0] {ST_IDLE, ST_LZA, ST_SHIFT, ST_FIX, ST_HOLD} state_t;

  state_t            state_reg;
  logic              ptr_reg;
  logic              id_reg;
  logic              zero_reg;
  logic [M:0]        a_reg, b_reg, sum_reg, mant_reg;
  logic [E-1:0]      exp_reg;
  logic [SW-1:0]     s_reg;
  logic signed [E:0] exp_tmp_reg;

  logic              out_valid_reg, out_id_reg, out_zero_reg, out_uflow_reg;
  logic [M:0]        out_mant_reg;
  logic [E-1:0]      out_exp_reg;

  logic [M:0]        a_in   [2];
  logic [M:0]        b_in   [2];
  logic [M:0]        sum_in [2];
  logic [E-1:0]      exp_in [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign a_in[gi]   = req_a[gi*(M+1) +: (M+1)];
      assign b_in[gi]   = req_b[gi*(M+1) +: (M+1)];
      assign sum_in[gi] = req_sum[gi*(M+1) +: (M+1)];
      assign exp_in[gi] = req_exp[gi*E +: E];
    end
  endgenerate

  // Pointer holder wins if valid; otherwise the other requester. Pointer only moves on accept.
  logic [1:0] grant;
  always_comb begin
    grant = 2'b00;
    if (req_valid[ptr_reg])
      grant[ptr_reg] = 1'b1;
    else if (req_valid[~ptr_reg])
      grant[~ptr_reg] = 1'b1;
  end

  logic gnt_id, accept;
  assign gnt_id    = grant[1];
  assign accept    = (state_reg == ST_IDLE) && (grant != 2'b00);
  assign req_ready = (rst_n && state_reg == ST_IDLE) ? grant : 2'b00;

  assign lza_a = (state_reg == ST_LZA) ? a_reg : '0;
  assign lza_b = (state_reg == ST_LZA) ? b_reg : '0;

  logic [SW-1:0]     s_lim;
  logic [M:0]        shifted;
  logic signed [E:0] exp_ext, s_ext;
  logic              uflow_cond;

  assign s_lim      = (lza_shift > SW'(M)) ? SW'(M) : lza_shift;
  assign shifted    = sum_reg << s_reg;
  assign exp_ext    = {1'b0, exp_reg};
  assign s_ext      = {{(E+1-SW){1'b0}}, s_reg};
  // exp <= s is equivalent to the running exp - s being zero or negative
  assign uflow_cond = exp_tmp_reg[E] || (exp_tmp_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= 1'b0;
      id_reg        <= 1'b0;
      zero_reg      <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      mant_reg      <= '0;
      exp_reg       <= '0;
      s_reg         <= '0;
      exp_tmp_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_id_reg    <= 1'b0;
      out_zero_reg  <= 1'b0;
      out_uflow_reg <= 1'b0;
      out_mant_reg  <= '0;
      out_exp_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            a_reg     <= a_in[gnt_id];
            b_reg     <= b_in[gnt_id];
            sum_reg   <= sum_in[gnt_id];
            exp_reg   <= exp_in[gnt_id];
            id_reg    <= gnt_id;
            ptr_reg   <= ~gnt_id;
            zero_reg  <= (sum_in[gnt_id] == '0);
            state_reg <= (sum_in[gnt_id] == '0) ? ST_HOLD : ST_LZA;
          end
        end
        ST_LZA: begin
          s_reg     <= s_lim;
          state_reg <= ST_SHIFT;
        end
        ST_SHIFT: begin
          mant_reg    <= shifted;
          exp_tmp_reg <= exp_ext - s_ext;
          state_reg   <= shifted[M] ? ST_HOLD : ST_FIX;
        end
        ST_FIX: begin
          mant_reg    <= mant_reg << 1;
          s_reg       <= s_reg + 1'b1;
          exp_tmp_reg <= exp_tmp_reg - (E+1)'(1);
          state_reg   <= ST_HOLD;
        end
        ST_HOLD: begin
          // First HOLD cycle loads the result registers; they then stay put until the handshake.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_id_reg    <= id_reg;
            if (zero_reg) begin
              out_zero_reg  <= 1'b1;
              out_uflow_reg <= 1'b0;
              out_mant_reg  <= '0;
              out_exp_reg   <= '0;
            end else if (uflow_cond) begin
              out_zero_reg  <= 1'b0;
              out_uflow_reg <= 1'b1;
              out_mant_reg  <= '0;
              out_exp_reg   <= '0;
            end else begin
              out_zero_reg  <= 1'b0;
              out_uflow_reg <= 1'b0;
              out_mant_reg  <= mant_reg;
              out_exp_reg   <= exp_tmp_reg[E-1:0];
            end
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_id    = out_id_reg;
  assign out_mant  = out_mant_reg;
  assign out_exp   = out_exp_reg;
  assign out_zero  = out_zero_reg;
  assign out_uflow = out_uflow_reg;

`ifdef HUB_NORM_STATS_EN
  logic [15:0] fix_cnt_reg, uflow_cnt_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fix_cnt_reg   <= '0;
      uflow_cnt_reg <= '0;
    end else begin
      if (state_reg == ST_FIX && fix_cnt_reg != 16'hFFFF)
        fix_cnt_reg <= fix_cnt_reg + 16'd1;
      if (state_reg == ST_HOLD && !out_valid_reg && !zero_reg && uflow_cond &&
          uflow_cnt_reg != 16'hFFFF)
        uflow_cnt_reg <= uflow_cnt_reg + 16'd1;
    end
  end
  assign fix_cnt   = fix_cnt_reg;
  assign uflow_cnt = uflow_cnt_reg;
`endif

endmodule

// File: tb/tb_hub_norm_arbiter.sv
// Directed bench for hub_norm_arbiter: vector table plus backpressure, reset and arbitration sequences.
module tb_hub_norm_arbiter;
  localparam int M  = 24;
  localparam int E  = 8;
  localparam int SW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [1:0]         req_valid, req_ready;
  logic [2*(M+1)-1:0] req_a, req_b, req_sum;
  logic [2*E-1:0]     req_exp;
  logic [M:0]         lza_a, lza_b;
  logic [SW-1:0]      lza_shift, lza_val;
  logic               out_valid, out_ready, out_id, out_zero, out_uflow;
  logic [M:0]         out_mant;
  logic [E-1:0]       out_exp;
`ifdef HUB_NORM_STATS_EN
  logic [15:0]        fix_cnt, uflow_cnt;
`endif

  assign lza_shift = lza_val;

  hub_norm_arbiter #(.M(M), .E(E), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sum(req_sum), .req_exp(req_exp),
    .lza_a(lza_a), .lza_b(lza_b), .lza_shift(lza_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero), .out_uflow(out_uflow)
`ifdef HUB_NORM_STATS_EN
    , .fix_cnt(fix_cnt), .uflow_cnt(uflow_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  typedef struct {
    logic          id;
    logic [M:0]    a, b, sum;
    logic [E-1:0]  ex;
    logic [SW-1:0] sh;
    logic [M:0]    x_mant;
    logic [E-1:0]  x_exp;
    logic          x_zero, x_uflow;
    int            x_lat;
  } vec_t;

  function automatic vec_t mk(input logic id, input logic [M:0] sum, input logic [E-1:0] ex,
                              input logic [SW-1:0] sh, input logic [M:0] xm, input logic [E-1:0] xe,
                              input logic xz, input logic xu, input int xl);
    vec_t v;
    v.id = id; v.sum = sum; v.ex = ex; v.sh = sh;
    v.a = sum ^ 25'h0AAAAAA; v.b = sum ^ 25'h1555555;
    v.x_mant = xm; v.x_exp = xe; v.x_zero = xz; v.x_uflow = xu; v.x_lat = xl;
    return v;
  endfunction

  task automatic set_slice(input logic id, input logic [M:0] a, input logic [M:0] b,
                           input logic [M:0] sum, input logic [E-1:0] ex);
    int base;
    base = id ? (M+1) : 0;
    req_a[base +: (M+1)]   = a;
    req_b[base +: (M+1)]   = b;
    req_sum[base +: (M+1)] = sum;
    req_exp[(id ? E : 0) +: E] = ex;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    set_slice(v.id, v.a, v.b, v.sum, v.ex);
    lza_val   = v.sh;
    req_valid = v.id ? 2'b10 : 2'b01;
    #1;
    chk("req_ready_grant", req_ready, v.id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    if (!v.x_zero) begin
      chk("lza_a", lza_a, v.a);
      chk("lza_b", lza_b, v.b);
    end
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL vec%0d_timeout: got no out_valid expected latency %0d", idx, v.x_lat);
    end else begin
      chk("latency", lat, v.x_lat);
      chk("out_id", out_id, v.id);
      chk("out_mant", out_mant, v.x_mant);
      chk("out_exp", out_exp, v.x_exp);
      chk("out_zero", out_zero, v.x_zero);
      chk("out_uflow", out_uflow, v.x_uflow);
      @(posedge clk); #1;
      chk("valid_drop", out_valid, 1'b0);
    end
    $display("vec%0d id=%0d sum=%h exp=%0d sh=%0d -> mant=%h exp=%0d zero=%0d uflow=%0d lat=%0d",
             idx, v.id, v.sum, v.ex, v.sh, out_mant, out_exp, out_zero, out_uflow, lat);
  endtask

  vec_t vecs [10];
  logic [M:0]   hold_mant;
  logic [E-1:0] hold_exp;
  logic         got;

  initial begin
    vecs[0] = mk(1'b0, 25'h0400000, 8'd100, 5'd2,  25'h1000000, 8'd98,  1'b0, 1'b0, 3);
    vecs[1] = mk(1'b0, 25'h0400000, 8'd100, 5'd1,  25'h1000000, 8'd98,  1'b0, 1'b0, 4);
    vecs[2] = mk(1'b0, 25'h0000000, 8'd50,  5'd7,  25'h0000000, 8'd0,   1'b1, 1'b0, 1);
    vecs[3] = mk(1'b0, 25'h0400000, 8'd2,   5'd2,  25'h0000000, 8'd0,   1'b0, 1'b1, 3);
    vecs[4] = mk(1'b1, 25'h0000001, 8'd30,  5'd24, 25'h1000000, 8'd6,   1'b0, 1'b0, 3);
    vecs[5] = mk(1'b1, 25'h1800000, 8'd10,  5'd0,  25'h1800000, 8'd10,  1'b0, 1'b0, 3);
    vecs[6] = mk(1'b0, 25'h0000003, 8'd200, 5'd31, 25'h1000000, 8'd176, 1'b0, 1'b0, 3);
    vecs[7] = mk(1'b0, 25'h0400000, 8'd2,   5'd1,  25'h0000000, 8'd0,   1'b0, 1'b1, 4);
    vecs[8] = mk(1'b1, 25'h0400000, 8'd3,   5'd2,  25'h1000000, 8'd1,   1'b0, 1'b0, 3);
    vecs[9] = mk(1'b0, 25'h0100000, 8'd100, 5'd2,  25'h0800000, 8'd97,  1'b0, 1'b0, 4);

    rst_n = 1'b0; out_ready = 1'b1; req_valid = 2'b01; lza_val = '0;
    req_a = '0; req_b = '0; req_sum = '0; req_exp = '0;
    #1;
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_mant", out_mant, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b00;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
`ifdef HUB_NORM_STATS_EN
    chk("fix_cnt", fix_cnt, 16'd3);
    chk("uflow_cnt", uflow_cnt, 16'd2);
`endif

    // Backpressure: requester 1 result held while requester 0 waits
    @(negedge clk);
    out_ready = 1'b0; lza_val = 5'd2;
    set_slice(1'b1, 25'h1, 25'h2, 25'h0400000, 8'd100);
    set_slice(1'b0, 25'h3, 25'h4, 25'h1000000, 8'd77);
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = 2'b01;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = 1'b1; break; end
    end
    chk("bp_valid_seen", got, 1'b1);
    chk("bp_mant", out_mant, 25'h1000000);
    chk("bp_exp", out_exp, 8'd98);
    chk("bp_id", out_id, 1'b1);
    hold_mant = out_mant; hold_exp = out_exp;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_mant", out_mant, hold_mant);
      chk("bp_hold_exp", out_exp, hold_exp);
      chk("bp_req_ready", req_ready, 2'b00);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done_valid", out_valid, 1'b0);
    chk("bp_idle_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    $display("backpressure id=1 mant=%h exp=%0d held 5 cycles", hold_mant, hold_exp);

    // Reset while in SHIFT
    @(negedge clk);
    set_slice(1'b0, 25'h5, 25'h6, 25'h0400000, 8'd100);
    lza_val = 5'd2; req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_slice(1'b0, 25'h7, 25'h8, 25'h1000000, 8'd100);
    set_slice(1'b1, 25'h9, 25'hA, 25'h1000000, 8'd50);
    lza_val = 5'd0; req_valid = 2'b11;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_mant", out_mant, '0);
    chk("rst_out_id", out_id, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_lza_a", lza_a, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_output", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset during SHIFT, released with req_valid=11");

    // Both requesters held valid: strict alternation starting from requester 0
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        checks++;
        if (req_ready == 2'b11) begin
          errors++;
          $display("FAIL arb_ready_onehot: got %b expected not 11", req_ready);
        end
        if (out_valid) begin
          got = 1'b1;
          chk("arb_id", out_id, t[0]);
          chk("arb_exp", out_exp, t[0] ? 8'd50 : 8'd100);
          chk("arb_mant", out_mant, 25'h1000000);
          $display("arb txn%0d id=%0d exp=%0d", t, out_id, out_exp);
          break;
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL arb_timeout: got no out_valid expected txn %0d", t);
      end
    end
    req_valid = 2'b00;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
